// File: rtl/fpcvt_seq_if.sv
// Handshake bundle for fpcvt_seq: sample input (valid/ready + D) and result output (valid/ready + S/E/F).
// With FPCVT_SEQ_STATUS_EN defined the bundle also carries sat and conv_cnt.
interface fpcvt_seq_if #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int MAN_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] D;
  logic              out_valid;
  logic              out_ready;
  logic              S;
  logic [EXP_W-1:0]  E;
  logic [MAN_W-1:0]  F;
`ifdef FPCVT_SEQ_STATUS_EN
  logic              sat;
  logic [15:0]       conv_cnt;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F, sat, conv_cnt
  );
  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F, sat, conv_cnt
  );
`else
  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F
  );
  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F
  );
`endif
endinterface

// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to small-float converter (S, E, F): one normalize shift per cycle.
// Optional status outputs (sat, conv_cnt) are enabled by defining FPCVT_SEQ_STATUS_EN.
module fpcvt_seq #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int MAN_W  = 4
) (
  input logic       clk,
  input logic       rst,
  fpcvt_seq_if.slave bus
);
  localparam int MAG_W  = DATA_W - 1;
  localparam int RB_POS = MAG_W - 1 - MAN_W;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               sgn_reg;
  logic               clamp_reg;
  logic               s_reg;
  logic [MAG_W-1:0]   mag_reg;
  logic [EXP_W-1:0]   exp_reg;
  logic [EXP_W-1:0]   e_reg;
  logic [MAN_W-1:0]   f_reg;
`ifdef FPCVT_SEQ_STATUS_EN
  logic               sat_reg;
  logic [15:0]        cnt_reg;
`endif

  logic               clamp_in;
  logic [MAG_W-1:0]   mag_in;
  logic [MAN_W:0]     f_sum;
  logic [EXP_W:0]     exp_sum;
  logic               round_sat;
  logic [EXP_W-1:0]   e_next;
  logic [MAN_W-1:0]   f_next;

  // The most negative sample has no positive twin in MAG_W bits, so it clamps to all ones.
  always_comb begin
    clamp_in = bus.D[DATA_W-1] & ~(|bus.D[MAG_W-1:0]);
    mag_in   = bus.D[DATA_W-1] ? (~bus.D[MAG_W-1:0] + MAG_W'(1)) : bus.D[MAG_W-1:0];
    if (clamp_in) begin
      mag_in = '1;
    end
  end

  always_comb begin
    f_sum     = {1'b0, mag_reg[MAG_W-1 -: MAN_W]} + (MAN_W+1)'(mag_reg[RB_POS]);
    exp_sum   = {1'b0, exp_reg} + (EXP_W+1)'(f_sum[MAN_W]);
    round_sat = exp_sum[EXP_W];
    f_next    = f_sum[MAN_W] ? {1'b1, {(MAN_W-1){1'b0}}} : f_sum[MAN_W-1:0];
    e_next    = exp_sum[EXP_W-1:0];
    if (round_sat) begin
      f_next = '1;
      e_next = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      sgn_reg       <= 1'b0;
      clamp_reg     <= 1'b0;
      s_reg         <= 1'b0;
      mag_reg       <= '0;
      exp_reg       <= '0;
      e_reg         <= '0;
      f_reg         <= '0;
`ifdef FPCVT_SEQ_STATUS_EN
      sat_reg       <= 1'b0;
      cnt_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            sgn_reg      <= bus.D[DATA_W-1];
            mag_reg      <= mag_in;
            clamp_reg    <= clamp_in;
            exp_reg      <= '1;
            in_ready_reg <= 1'b0;
`ifdef FPCVT_SEQ_STATUS_EN
            sat_reg      <= 1'b0;
`endif
            state_reg    <= NORM;
          end
        end
        NORM: begin
          if (mag_reg[MAG_W-1] || (exp_reg == '0)) begin
            state_reg <= ROUND;
          end else begin
            mag_reg <= {mag_reg[MAG_W-2:0], 1'b0};
            exp_reg <= exp_reg - EXP_W'(1);
          end
        end
        ROUND: begin
          s_reg         <= sgn_reg;
          e_reg         <= e_next;
          f_reg         <= f_next;
          out_valid_reg <= 1'b1;
`ifdef FPCVT_SEQ_STATUS_EN
          sat_reg       <= round_sat | clamp_reg;
`endif
          state_reg     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
`ifdef FPCVT_SEQ_STATUS_EN
            cnt_reg       <= cnt_reg + 16'd1;
`endif
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.S         = s_reg;
  assign bus.E         = e_reg;
  assign bus.F         = f_reg;
`ifdef FPCVT_SEQ_STATUS_EN
  assign bus.sat       = sat_reg;
  assign bus.conv_cnt  = cnt_reg;
`endif
endmodule

// File: tb/tb_fpcvt_seq.sv
// Self-checking bench for fpcvt_seq: directed corner samples, output stall, streaming, random traffic, reset abort.
// Expected S/E/F, latency and sat come from an arithmetic reference (round-half-up of |D| / 2^E).
module tb_fpcvt_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpcvt_seq_if bus ();
  fpcvt_seq dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [11:0] stream_d [64];

  // Reference: E is the smallest exponent that fits |D| into 4 bits, F rounds half-up.
  function automatic void ref_model(input logic [11:0] d, output logic s, output int e,
                                    output int f, output int k, output bit sat);
    int x;
    int m;
    int bl;
    x   = $signed(d);
    s   = (x < 0);
    m   = (x < 0) ? -x : x;
    sat = (m > 2047);
    if (m > 2047) m = 2047;
    bl = 0;
    while (bl < 16 && (m >> bl) != 0) bl++;
    e = (bl > 4) ? bl - 4 : 0;
    k = 7 - e;
    f = (e > 0) ? ((m + (1 << (e - 1))) >> e) : m;
    if (f == 16) begin
      f = 8;
      e = e + 1;
    end
    if (e > 7) begin
      e   = 7;
      f   = 15;
      sat = 1'b1;
    end
  endfunction

  task automatic do_convert(input logic [11:0] d);
    logic s;
    int e, f, k, cyc;
    bit sat, ok, rdy_seen;
    ref_model(d, s, e, f, k, sat);
    @(negedge clk);
    bus.D = d; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL accept_ready d=%h in_ready=%b required=1", d, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.D = 12'($urandom);
    cyc = 0; ok = 0; rdy_seen = 0;
    while (cyc < 20) begin
      if (bus.out_valid === 1'b1) begin ok = 1; break; end
      if (bus.in_ready !== 1'b0) rdy_seen = 1;
      @(negedge clk); cyc++;
    end
    checks++;
    if (!ok || cyc != k + 2) begin
      failures++; $display("FAIL latency d=%h edges=%0d required=%0d (seen=%0b)", d, cyc, k + 2, ok);
    end
    checks++;
    if (rdy_seen || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL busy_ready d=%h in_ready went high during conversion", d);
    end
    checks++;
    if (bus.S !== s || bus.E !== 3'(e) || bus.F !== 4'(f)) begin
      failures++; $display("FAIL result d=%h S/E/F=%b/%0d/%0d required=%b/%0d/%0d", d, bus.S, bus.E, bus.F, s, e, f);
    end
`ifdef FPCVT_SEQ_STATUS_EN
    checks++;
    if (bus.sat !== sat) begin
      failures++; $display("FAIL sat d=%h sat=%b required=%b", d, bus.sat, sat);
    end
`endif
    $display("convert d=%h -> S=%b E=%0d F=%0d after %0d edges", d, bus.S, bus.E, bus.F, cyc);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt++;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL release d=%h out_valid=%b in_ready=%b required=0/1", d, bus.out_valid, bus.in_ready);
    end
    checks++;
    if (bus.S !== s || bus.E !== 3'(e) || bus.F !== 4'(f)) begin
      failures++; $display("FAIL retain d=%h S/E/F=%b/%0d/%0d required=%b/%0d/%0d", d, bus.S, bus.E, bus.F, s, e, f);
    end
`ifdef FPCVT_SEQ_STATUS_EN
    checks++;
    if (bus.conv_cnt !== 16'(exp_cnt)) begin
      failures++; $display("FAIL conv_cnt value=%0d required=%0d", bus.conv_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic run_stream(input int n, input bit stall);
    int idx, got, cyc, e, f, k;
    logic s;
    bit acc, hs, sat;
    idx = 0; got = 0; cyc = 0;
    @(negedge clk);
    bus.D = stream_d[0]; bus.in_valid = 1'b1;
    bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (got < n && cyc < 2000) begin
      acc = bus.in_ready && bus.in_valid;
      hs  = bus.out_valid && bus.out_ready;
      if (hs) begin
        ref_model(stream_d[got], s, e, f, k, sat);
        checks++;
        if (bus.S !== s || bus.E !== 3'(e) || bus.F !== 4'(f)) begin
          failures++; $display("FAIL stream[%0d] d=%h S/E/F=%b/%0d/%0d required=%b/%0d/%0d",
                               got, stream_d[got], bus.S, bus.E, bus.F, s, e, f);
        end
        $display("stream[%0d] d=%h -> S=%b E=%0d F=%0d", got, stream_d[got], bus.S, bus.E, bus.F);
        got++; exp_cnt++;
      end
      @(negedge clk); cyc++;
      if (acc) begin
        idx++;
        if (idx < n) bus.D = stream_d[idx];
        else begin bus.in_valid = 1'b0; bus.D = 12'($urandom); end
      end
      bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (got != n) begin
      failures++; $display("FAIL stream_count results=%0d required=%0d", got, n);
    end
`ifdef FPCVT_SEQ_STATUS_EN
    @(negedge clk);
    checks++;
    if (bus.conv_cnt !== 16'(exp_cnt)) begin
      failures++; $display("FAIL stream_conv_cnt value=%0d required=%0d", bus.conv_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.S !== 1'b0 || bus.E !== 3'd0 || bus.F !== 4'd0) begin
      failures++; $display("FAIL reset rdy/vld/S/E/F=%b/%b/%b/%0d/%0d required=1/0/0/0/0",
                           bus.in_ready, bus.out_valid, bus.S, bus.E, bus.F);
    end
`ifdef FPCVT_SEQ_STATUS_EN
    checks++;
    if (bus.sat !== 1'b0 || bus.conv_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_status sat=%b conv_cnt=%0d required=0/0", bus.sat, bus.conv_cnt);
    end
`endif
    $display("reset released");
    rst = 1'b0; exp_cnt = 0;
  endtask

  task automatic test_directed();
    logic [11:0] vec [6];
    vec = '{12'h000, 12'h02C, 12'h07D, 12'h7FF, 12'h800, 12'hFFF};
    foreach (vec[i]) do_convert(vec[i]);
    for (int i = 0; i < 8; i++) do_convert(12'($urandom));
  endtask

  task automatic test_hold();
    logic s0;
    logic [2:0] e0;
    logic [3:0] f0;
    int cyc;
    @(negedge clk);
    bus.D = 12'hFFF; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    s0 = bus.S; e0 = bus.E; f0 = bus.F;
    checks++;
    if (s0 !== 1'b1 || e0 !== 3'd0 || f0 !== 4'd1) begin
      failures++; $display("FAIL hold_result S/E/F=%b/%0d/%0d required=1/0/1", s0, e0, f0);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.S !== s0 || bus.E !== e0 || bus.F !== f0 || bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_stable cycle=%0d vld/S/E/F=%b/%b/%0d/%0d required=1/%b/%0d/%0d",
                             i, bus.out_valid, bus.S, bus.E, bus.F, s0, e0, f0);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0; exp_cnt++;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release out_valid=%b in_ready=%b required=0/1", bus.out_valid, bus.in_ready);
    end
    $display("hold d=fff stalled 5 cycles then released");
  endtask

  task automatic test_back_to_back();
    stream_d[0] = 12'h02C; stream_d[1] = 12'hFFF; stream_d[2] = 12'h07D;
    run_stream(3, 1'b0);
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       stream_d[i] = 12'($urandom_range(0, 15));
        1:       stream_d[i] = 12'h800 + 12'($urandom_range(0, 3));
        default: stream_d[i] = 12'($urandom);
      endcase
    end
    run_stream(30, 1'b1);
  endtask

  task automatic test_reset_abort();
    int cyc;
    bit seen;
    do_convert(12'h02C);
    @(negedge clk);
    bus.D = 12'hFFF; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.S !== 1'b0 || bus.E !== 3'd0 || bus.F !== 4'd0) begin
      failures++; $display("FAIL abort_reset vld/rdy/S/E/F=%b/%b/%b/%0d/%0d required=0/1/0/0/0",
                           bus.out_valid, bus.in_ready, bus.S, bus.E, bus.F);
    end
    rst = 1'b0; exp_cnt = 0;
    seen = 0;
    for (cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL abort_no_output out_valid rose after reset abort, required none");
    end
    $display("abort d=fff reset during NORM, no output");
    do_convert(12'h07D);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.D = '0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_random_stream();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
